// File: rtl/sensor_pkg.sv
// sensor_pkg: shared types and the bank error equation for sensor_scan_ctrl.
// Provides scan_state_t and bank_err().
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CONFIRM,
    ALARM
  } scan_state_t;

  function automatic logic bank_err(input logic [3:0] s);
    return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: rollover counter, 0..DIV-1, tick at terminal count.
// Ports: clk, rst (async high), clear, count_en -> tick (combinational).
module scan_timer #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TC = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = count_en && (cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin sensor bank scanner with debounced, latched alarm.
// Ports: clk, rst (async high), enable, sensors[4*NUM_BANKS], alarm_ack ->
//   bank_sel, busy, alarm, alarm_bank, err_count (only with SENSOR_SCAN_ERRCNT_EN).
module sensor_scan_ctrl
  import sensor_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int SAMPLE_DIV = 8,
  parameter int DEBOUNCE   = 3
`ifdef SENSOR_SCAN_ERRCNT_EN
  ,
  parameter int ERRCNT_W   = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [4*NUM_BANKS-1:0]       sensors,
  input  logic                         alarm_ack,
  output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic                         busy,
  output logic                         alarm,
  output logic [$clog2(NUM_BANKS)-1:0] alarm_bank
`ifdef SENSOR_SCAN_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]          err_count
`endif
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int HW = $clog2(DEBOUNCE + 1);
  localparam logic [BW-1:0] LAST = BW'(NUM_BANKS - 1);
  localparam logic [HW-1:0] DEB  = HW'(DEBOUNCE);
  localparam logic [HW-1:0] ONE  = HW'(1);

  scan_state_t   state, state_n;
  logic [BW-1:0] bank_n, abank_n, bank_inc;
  logic [HW-1:0] hits, hits_n, hits_inc;
  logic          alarm_n;
  logic          tick, run, err, enter;
  logic [3:0]    banks [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign banks[i] = sensors[4*i +: 4];
  end

  assign err      = bank_err(banks[bank_sel]);
  assign bank_inc = (bank_sel == LAST) ? '0 : bank_sel + 1'b1;
  assign hits_inc = hits + 1'b1;
  assign run      = (state == SCAN) || (state == CONFIRM);
  assign busy     = (state != IDLE);

  scan_timer #(
    .DIV(SAMPLE_DIV)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!run),
    .count_en(run),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    bank_n  = bank_sel;
    hits_n  = hits;
    alarm_n = alarm;
    abank_n = alarm_bank;
    enter   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_n = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_n = IDLE;
          hits_n  = '0;
        end else if (tick) begin
          if (err) begin
            hits_n = ONE;
            if (DEB == ONE) enter = 1'b1;
            else state_n = CONFIRM;
          end else begin
            bank_n = bank_inc;
          end
        end
      end
      CONFIRM: begin
        if (!enable) begin
          state_n = IDLE;
          hits_n  = '0;
        end else if (tick) begin
          if (err) begin
            hits_n = hits_inc;
            if (hits_inc == DEB) enter = 1'b1;
          end else begin
            hits_n  = '0;
            bank_n  = bank_inc;
            state_n = SCAN;
          end
        end
      end
      ALARM: begin
        if (alarm_ack) begin
          alarm_n = 1'b0;
          hits_n  = '0;
          bank_n  = bank_inc;
          state_n = enable ? SCAN : IDLE;
        end
      end
    endcase
    if (enter) begin
      state_n = ALARM;
      alarm_n = 1'b1;
      abank_n = bank_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bank_sel   <= '0;
      hits       <= '0;
      alarm      <= 1'b0;
      alarm_bank <= '0;
    end else begin
      state      <= state_n;
      bank_sel   <= bank_n;
      hits       <= hits_n;
      alarm      <= alarm_n;
      alarm_bank <= abank_n;
    end
  end

`ifdef SENSOR_SCAN_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = err_count;
    if (enter && (err_count != '1)) cnt_n = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else     err_count <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: directed test of sensor_scan_ctrl against a cycle model.
// Optional err_count checks when SENSOR_SCAN_ERRCNT_EN is defined.
module tb_sensor_scan_ctrl;

  localparam int NB  = 4;
  localparam int DIV = 8;
  localparam int DEB = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [4*NB-1:0] sensors = '0;
  logic          alarm_ack = 1'b0;
  logic [1:0]    bank_sel;
  logic          busy;
  logic          alarm;
  logic [1:0]    alarm_bank;
`ifdef SENSOR_SCAN_ERRCNT_EN
  logic [CW-1:0] err_count;
`endif

  int checks = 0;
  int passes = 0;
  bit mon = 1'b0;

  sensor_scan_ctrl #(
    .NUM_BANKS (NB),
    .SAMPLE_DIV(DIV),
    .DEBOUNCE  (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sensors   (sensors),
    .alarm_ack (alarm_ack),
    .bank_sel  (bank_sel),
    .busy      (busy),
    .alarm     (alarm),
    .alarm_bank(alarm_bank)
`ifdef SENSOR_SCAN_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: scanning is "active and not alarmed"; a run of
  // consecutive erroring ticks on the current bank triggers the alarm.
  bit m_act, m_alarm;
  int m_bank, m_abank, m_run, m_div, m_cnt;

  function automatic bit m_err(input logic [3:0] s);
    return s[0] || (s[1] && (s[2] || s[3]));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_alarm = 0; m_bank = 0;
      m_abank = 0; m_run = 0; m_div = 0; m_cnt = 0;
    end else if (m_alarm) begin
      m_div = 0;
      if (alarm_ack) begin
        m_alarm = 0;
        m_run = 0;
        m_bank = (m_bank + 1) % NB;
        m_act = enable;
      end
    end else if (!m_act) begin
      m_div = 0;
      if (enable) m_act = 1;
    end else if (!enable) begin
      m_act = 0; m_run = 0; m_div = 0;
    end else if (m_div == DIV - 1) begin
      m_div = 0;
      if (m_err(sensors[m_bank*4 +: 4])) begin
        m_run++;
        if (m_run == DEB) begin
          m_alarm = 1;
          m_abank = m_bank;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end else begin
        m_run = 0;
        m_bank = (m_bank + 1) % NB;
      end
    end else begin
      m_div++;
    end
  end

  always @(negedge clk) begin
    if (mon && !rst) begin
      chk("m_bank_sel", 32'(bank_sel), 32'(m_bank));
      chk("m_busy", 32'(busy), 32'(m_act || m_alarm));
      chk("m_alarm", 32'(alarm), 32'(m_alarm));
      chk("m_alarm_bank", 32'(alarm_bank), 32'(m_abank));
`ifdef SENSOR_SCAN_ERRCNT_EN
      chk("m_err_count", 32'(err_count), 32'(m_cnt));
`endif
    end
  end

  task automatic wait_alarm(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (alarm) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    step(3);
    rst = 1'b0;
    mon = 1'b1;
    chk("rst_bank", 32'(bank_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_abank", 32'(alarm_bank), 0);

    // clean scan
    enable = 1'b1;
    step(9);
    chk("scan_b1", 32'(bank_sel), 1);
    chk("scan_busy", 32'(busy), 1);
    step(8);
    chk("scan_b2", 32'(bank_sel), 2);
    step(8);
    chk("scan_b3", 32'(bank_sel), 3);
    step(8);
    chk("scan_wrap", 32'(bank_sel), 0);
    chk("scan_noalarm", 32'(alarm), 0);

    // debounced alarm on bank 2
    sensors = 16'h0100;
    step(39);
    chk("deb_early", 32'(alarm), 0);
    step(1);
    chk("deb_alarm", 32'(alarm), 1);
    chk("deb_abank", 32'(alarm_bank), 2);
    step(5);
    chk("deb_hold", 32'(alarm), 1);
    sensors = '0;
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    chk("ack_clear", 32'(alarm), 0);
    chk("ack_bank", 32'(bank_sel), 3);
    chk("ack_busy", 32'(busy), 1);

    // glitch on bank 1 for two ticks
    step(8);
    chk("gl_b0", 32'(bank_sel), 0);
    sensors = 16'h0060;
    step(24);
    chk("gl_held", 32'(bank_sel), 1);
    chk("gl_noalarm", 32'(alarm), 0);
    sensors = '0;
    step(8);
    chk("gl_adv", 32'(bank_sel), 2);
    chk("gl_noalarm2", 32'(alarm), 0);

    // 4'b1100 is clean, 4'b1010 errors (s1&s3)
    sensors = 16'h000C;
    step(24);
    chk("p1100_adv", 32'(bank_sel), 1);
    step(32);
    chk("p1100_round", 32'(bank_sel), 1);
    chk("p1100_noalarm", 32'(alarm), 0);
    sensors = 16'h000A;
    step(47);
    chk("p1010_early", 32'(alarm), 0);
    step(1);
    chk("p1010_alarm", 32'(alarm), 1);
    chk("p1010_abank", 32'(alarm_bank), 0);

    // disable ignored in alarm; ack held high not remembered
    sensors = '0;
    enable = 1'b0;
    step(3);
    chk("dis_in_alarm", 32'(alarm), 1);
    chk("dis_busy", 32'(busy), 1);
    alarm_ack = 1'b1;
    step(1);
    chk("ackdis_alarm", 32'(alarm), 0);
    chk("ackdis_idle", 32'(busy), 0);
    chk("ackdis_bank", 32'(bank_sel), 1);
    step(2);
    alarm_ack = 1'b0;
    chk("ackheld_idle", 32'(busy), 0);

    // disable mid-confirm, then restart debounce
    sensors = 16'h0010;
    enable = 1'b1;
    step(17);
    chk("mc_busy", 32'(busy), 1);
    chk("mc_noalarm", 32'(alarm), 0);
    enable = 1'b0;
    step(1);
    chk("mc_idle", 32'(busy), 0);
    chk("mc_bank", 32'(bank_sel), 1);
    step(20);
    chk("mc_noalarm2", 32'(alarm), 0);
    enable = 1'b1;
    step(24);
    chk("re_early", 32'(alarm), 0);
    step(1);
    chk("re_alarm", 32'(alarm), 1);
    chk("re_abank", 32'(alarm_bank), 1);

    // async reset while alarmed
    rst = 1'b1;
    #1;
    chk("ar_alarm", 32'(alarm), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_bank", 32'(bank_sel), 0);
    chk("ar_abank", 32'(alarm_bank), 0);
`ifdef SENSOR_SCAN_ERRCNT_EN
    chk("ar_cnt", 32'(err_count), 0);
`endif
    step(2);
    sensors = 16'h1111;
    rst = 1'b0;

`ifdef SENSOR_SCAN_ERRCNT_EN
    for (int k = 0; k < 300; k++) begin
      wait_alarm(100, ok);
      if (!ok) begin
        chk("cnt_timeout", 0, 1);
        break;
      end
      step(1);
      if (k == 0) chk("cnt_first", 32'(err_count), 1);
      alarm_ack = 1'b1;
      step(1);
      alarm_ack = 1'b0;
    end
    chk("cnt_sat", 32'(err_count), 255);
`else
    wait_alarm(100, ok);
    chk("post_rst_alarm", 32'(ok), 1);
    chk("post_rst_abank", 32'(alarm_bank), 0);
`endif

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
